// File: rtl/booth_seq_ctrl.sv
// Iterative radix-4 Booth multiplier sequencer: one Booth digit per cycle into a 2*WIDTH accumulator.
// Optional macro BOOTH_SEQ_EARLY_EXIT_EN ends CALC early once every remaining digit is zero.
module booth_seq_ctrl #(
  parameter int WIDTH = 8,
  localparam int NDIG = WIDTH / 2,
  localparam int DIW  = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy,
  output logic [DIW-1:0]     digit_idx
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   x_ext;
  logic [WIDTH:0]  y_ext;
  logic [PW-1:0]   acc;
  logic [DIW-1:0]  cnt;

  logic [2:0]      win;
  logic            pp_zero, pp_inv, pp_dbl;
  logic [PW-1:0]   pp_mag, pp, pp_shifted, acc_sum;
  logic            early_exit, last_digit;

  // Booth window for digit cnt is y_ext[2cnt+2 : 2cnt].
  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win        = 3'(y_ext >> {cnt, 1'b0});
    pp_zero    = (win == 3'b000) || (win == 3'b111);
    pp_inv     = win[2];
    pp_dbl     = ~(win[1] ^ win[0]);
    pp_mag     = pp_dbl ? (x_ext << 1) : x_ext;
    pp         = '0;
    if (!pp_zero) pp = pp_inv ? -pp_mag : pp_mag;
    pp_shifted = pp << {cnt, 1'b0};
    acc_sum    = acc + pp_shifted;
  end

`ifdef BOOTH_SEQ_EARLY_EXIT_EN
  // Remaining multiplier bits Y[WIDTH-1:2cnt+1] all equal means every later digit is zero.
  logic [WIDTH-1:0] y_rest;
  assign y_rest     = $signed(y_ext[WIDTH:1]) >>> {cnt, 1'b1};
  assign early_exit = (y_rest == '0) || (y_rest == '1);
`else
  assign early_exit = 1'b0;
`endif

  assign last_digit = (cnt == DIW'(NDIG - 1)) || early_exit;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = CALC;
      CALC:    if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: operand and accumulator registers are reset too, so out_p reads 0 after reset rather than X.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_ext <= '0;
      y_ext <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_ext <= {{WIDTH{in_x[WIDTH-1]}}, in_x};
          y_ext <= {in_y, 1'b0};
          acc   <= '0;
          cnt   <= '0;
        end
        CALC: begin
          acc <= acc_sum;
          if (!last_digit) cnt <= cnt + DIW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign out_p     = acc;
  assign busy      = (state != IDLE);
  assign digit_idx = (state == CALC) ? cnt : '0;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: directed cases plus randomized traffic against a
// plain-arithmetic product/latency model (latency model follows BOOTH_SEQ_EARLY_EXIT_EN).
module tb_booth_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int NDIG  = WIDTH / 2;
  localparam int DIW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x, in_y;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_p;
  logic             busy;
  logic [DIW-1:0]   digit_idx;

  int checks = 0;
  int errors = 0;

  booth_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .busy     (busy),
    .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] model_prod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[PW-1:0];
  endfunction

  // Cycles spent in CALC: with early exit, the fewest digits k whose 2k-bit signed range holds Y.
  function automatic int model_lat(input logic [WIDTH-1:0] y);
`ifdef BOOTH_SEQ_EARLY_EXIT_EN
    int v;
    v = int'($signed(y));
    for (int k = 1; k < NDIG; k++)
      if (v >= -(1 << (2*k-1)) && v < (1 << (2*k-1))) return k;
`endif
    return NDIG;
  endfunction

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(WIDTH-1){1'b0}}};
      1:       return {1'b0, {(WIDTH-1){1'b1}}};
      2:       return '1;
      3:       return WIDTH'($urandom_range(0, 3));
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE, holding the result for 'hold' cycles of backpressure.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int hold);
    int n;
    logic [PW-1:0] held;
    check("pre_in_ready", in_ready, 1);
    in_x = x; in_y = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_x = WIDTH'($urandom); in_y = WIDTH'($urandom);
    check("accept_busy", busy, 1);
    n = 0;
    while (!out_valid && n < 4 * NDIG) begin
      check("calc_digit_idx", digit_idx, n);
      check("calc_in_ready", in_ready, 0);
      tick();
      n++;
    end
    check("latency", n, model_lat(y));
    check("product", out_p, model_prod(x, y));
    check("done_digit_idx", digit_idx, 0);
    held = out_p;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_x = WIDTH'($urandom); in_y = WIDTH'($urandom);
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_p", out_p, held);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
  endtask

  logic [PW-1:0] exp_q[$];
  int            lat_q[$];
  int            acc_q[$];
  int            accepted, retired;
  logic          prev_valid, prev_taken;
  logic [PW-1:0] prev_p;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_p", out_p, 0);
    check("rst_digit_idx", digit_idx, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);

    run_op(8'd3, 8'd5, 0);
    run_op(8'h80, 8'h80, 0);
    run_op(8'h7F, 8'h80, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'd25, 8'd1, 0);
    run_op(8'd25, 8'hFE, 0);
    run_op(8'd25, 8'd64, 0);
    run_op(8'd3, 8'hF9, 10);

    // idle with no request stays idle
    repeat (3) tick();
    check("idle_stays", busy, 0);

    // reset during CALC at digit 2
    in_x = 8'd7; in_y = 8'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mid_digit_idx", digit_idx, 2);
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_acc", out_p, 0);
    check("mid_rst_digit_idx", digit_idx, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_release", in_ready, 1);
    run_op(8'd2, 8'hFD, 0);

    // reset while holding a result in DONE
    in_x = 8'd11; in_y = 8'd13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4 * NDIG && !out_valid; i++) tick();
    check("done_before_rst", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("done_rst_out_valid", out_valid, 0);
    check("done_rst_out_p", out_p, 0);
    check("done_rst_busy", busy, 0);
    #1;

    // randomized traffic with random request gaps and consumer backpressure
    accepted = 0; retired = 0;
    prev_valid = 1'b0; prev_taken = 1'b0; prev_p = '0;
    for (int i = 0; i < 20000; i++) begin
      if (i < 19960) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      in_x = rand_operand();
      in_y = rand_operand();
      @(negedge clk);
      if (prev_valid && !prev_taken) begin
        check("rnd_hold_valid", out_valid, 1);
        check("rnd_hold_p", out_p, prev_p);
      end
      if (out_valid && !prev_valid && acc_q.size() > 0)
        check("rnd_latency", i - acc_q[0] - 1, lat_q[0]);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious", exp_q.size(), 1);
        end else begin
          check("rnd_product", out_p, exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(acc_q.pop_front());
        end
        retired++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_prod(in_x, in_y));
        lat_q.push_back(model_lat(in_y));
        acc_q.push_back(i);
        accepted++;
      end
      prev_valid = out_valid;
      prev_taken = out_valid && out_ready;
      prev_p     = out_p;
      @(posedge clk);
      #1;
    end
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_count", retired, accepted);
    check("rnd_final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
